pal_cfg_loader: RTL and testbench

- On-chip configuration sequencer for the PAL fabric.
- Accepts the configuration bitstream as bytes over a valid/ready handshake and serializes it onto the PAL's serial configuration port (config bit plus configuration clock).
- Asserts the PAL output enable once the full bitstream has been shifted in.
- Replaces host bit-banging of the config/clk_pal lines; sits between the tile IO and the PAL core.

---
 rtl/pal_pkg.sv | 28 ++
 rtl/pal_cfg_clkgen.sv | 43 ++++
 rtl/pal_cfg_loader.sv | 166 ++++++++++++++++
 tb/tb_pal_cfg_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// Shared constants, bitstream sizing and loader state encoding for the PAL
// configuration path.
package pal_pkg;

    localparam int NUM_INPUTS        = 8;
    localparam int NUM_INTERM_STAGES = 10;
    localparam int NUM_OUTPUTS       = 4;

    // Phase counter width; wide enough for the largest legal CLK_DIV of 15.
    localparam int PHASE_W = 4;

    // AND-plane takes true and complement of every input per product term;
    // OR-plane takes one bit per product term per output.
    function automatic int bitstream_len(input int n_in, input int n_terms, input int n_out);
        return 2 * n_in * n_terms + n_terms * n_out;
    endfunction

    localparam int CNT_W = $clog2(bitstream_len(NUM_INPUTS, NUM_INTERM_STAGES, NUM_OUTPUTS) + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_HIGH,
        ST_LOADED
    } loader_state_e;

endpackage

// File: rtl/pal_cfg_clkgen.sv
// Phase timer for the configuration clock: counts CLK_DIV system cycles per
// SETUP/HIGH phase and strobes phase_done_o on the last cycle of each phase.
module pal_cfg_clkgen
    import pal_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic phase_done_o
);

    localparam logic [PHASE_W-1:0] LAST_CNT = PHASE_W'(CLK_DIV - 1);

    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] cnt_d;

    assign phase_done_o = en_i && !clr_i && (cnt_q == LAST_CNT);

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || phase_done_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// Byte-fed configuration sequencer: serialises the PAL bitstream LSB-first
// onto cfg_bit/cfg_clk and enables the PAL once the whole stream is in.
module pal_cfg_loader #(
    parameter int  NUM_INPUTS        = pal_pkg::NUM_INPUTS,
    parameter int  NUM_INTERM_STAGES = pal_pkg::NUM_INTERM_STAGES,
    parameter int  NUM_OUTPUTS       = pal_pkg::NUM_OUTPUTS,
    parameter int  CLK_DIV           = 2,
    localparam int BITSTREAM_LEN     = pal_pkg::bitstream_len(NUM_INPUTS, NUM_INTERM_STAGES,
                                                              NUM_OUTPUTS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [7:0]                         byte_data,
    input  logic                               byte_valid,
    output logic                               byte_ready,
    output logic                               cfg_bit,
    output logic                               cfg_clk,
    output logic                               pal_enable,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(BITSTREAM_LEN+1)-1:0] bit_count
);

    import pal_pkg::*;

    localparam int                  BIT_CNT_W = $clog2(BITSTREAM_LEN + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITSTREAM_LEN);

    loader_state_e        state_q, state_d;
    logic [7:0]           byte_q, byte_d;
    logic [2:0]           idx_q, idx_d;
    logic [BIT_CNT_W-1:0] bit_count_q, bit_count_d;
    logic                 cfg_bit_q, cfg_bit_d;
    logic                 cfg_clk_q, cfg_clk_d;
    logic                 pal_enable_q, pal_enable_d;
    logic                 done_q, done_d;

    logic                 phase_en;
    logic                 phase_done;

    assign phase_en = (state_q == ST_SETUP) || (state_q == ST_HIGH);

    pal_cfg_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (phase_en),
        .clr_i        (abort),
        .phase_done_o (phase_done)
    );

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        idx_d        = idx_q;
        bit_count_d  = bit_count_q;
        pal_enable_d = pal_enable_q;
        byte_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    bit_count_d  = '0;
                    pal_enable_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        byte_d  = byte_data;
                        idx_d   = 3'd0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phase_done) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phase_done) begin
                    bit_count_d = bit_count_q + 1'b1;
                    // A short final byte ends here; its unused upper bits are dropped.
                    if (bit_count_d == LAST_BIT) begin
                        pal_enable_d = 1'b1;
                        state_d      = ST_LOADED;
                    end else if (idx_q == 3'd7) begin
                        state_d = ST_FETCH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_LOADED: begin
                if (abort) begin
                    pal_enable_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (start) begin
                    pal_enable_d = 1'b0;
                    bit_count_d  = '0;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // cfg_clk/cfg_bit come straight from dedicated flops fed by the next state,
    // so the PAL sees clean edges with no input-to-output combinational path.
    always_comb begin
        cfg_clk_d = (state_d == ST_HIGH);
        if ((state_d == ST_SETUP) || (state_d == ST_HIGH)) begin
            cfg_bit_d = byte_d[idx_d];
        end else if (state_d == ST_IDLE) begin
            cfg_bit_d = 1'b0;
        end else begin
            cfg_bit_d = cfg_bit_q;
        end
        done_d = (state_d == ST_LOADED) && (state_q != ST_LOADED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_q       <= '0;
            idx_q        <= '0;
            bit_count_q  <= '0;
            cfg_bit_q    <= 1'b0;
            cfg_clk_q    <= 1'b0;
            pal_enable_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            idx_q        <= idx_d;
            bit_count_q  <= bit_count_d;
            cfg_bit_q    <= cfg_bit_d;
            cfg_clk_q    <= cfg_clk_d;
            pal_enable_q <= pal_enable_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q == ST_FETCH) || (state_q == ST_SETUP) || (state_q == ST_HIGH);
    assign cfg_bit    = cfg_bit_q;
    assign cfg_clk    = cfg_clk_q;
    assign pal_enable = pal_enable_q;
    assign done       = done_q;
    assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench: default loader plus a 190-bit, CLK_DIV=1 variant,
// compared against a PAL-side shift register fed from the byte stream.
module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0, abort = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;

    logic       rdy1, bit1, cclk1, pe1, busy1, done1;
    logic [7:0] bc1;
    logic       rdy2, bit2, cclk2, pe2, busy2, done2;
    logic [7:0] bc2;

    bit         sel = 1'b0;   // 0: default DUT, 1: 190-bit fast DUT

    always #5 clk = ~clk;

    pal_cfg_loader u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(rdy1),
        .cfg_bit(bit1), .cfg_clk(cclk1), .pal_enable(pe1), .busy(busy1),
        .done(done1), .bit_count(bc1)
    );

    pal_cfg_loader #(.NUM_OUTPUTS(3), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(rdy2),
        .cfg_bit(bit2), .cfg_clk(cclk2), .pal_enable(pe2), .busy(busy2),
        .done(done2), .bit_count(bc2)
    );

    logic       rdy_m, bit_m, cclk_m, pe_m, busy_m, done_m;
    logic [7:0] bc_m;
    assign rdy_m  = sel ? rdy2  : rdy1;
    assign bit_m  = sel ? bit2  : bit1;
    assign cclk_m = sel ? cclk2 : cclk1;
    assign pe_m   = sel ? pe2   : pe1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;
    assign bc_m   = sel ? bc2   : bc1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- PAL-side model: shift register sampled on negedge ----
    int   cyc = 0, rise_cnt = 0, viol = 0, done_cnt = 0, stable = 0;
    bit   cap[0:4095];
    int   rise_cyc[0:4095];
    logic clk_prev = 1'b0, bit_prev = 1'b0;
    int   cur_div, st_now;
    logic rise, bad_hold, bad_setup, bad_stall;

    assign cur_div   = sel ? 1 : 2;
    assign st_now    = (bit_m == bit_prev) ? stable + 1 : 0;
    assign rise      = rst_n && cclk_m && !clk_prev;
    assign bad_hold  = rst_n && cclk_m && clk_prev && (bit_m != bit_prev);
    assign bad_setup = rise && (st_now < cur_div);
    assign bad_stall = rst_n && rdy_m && cclk_m;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            clk_prev <= 1'b0;
            bit_prev <= 1'b0;
            stable   <= 0;
        end else begin
            clk_prev <= cclk_m;
            bit_prev <= bit_m;
            stable   <= st_now;
            done_cnt <= done_cnt + int'(done_m);
            viol     <= viol + int'(bad_hold) + int'(bad_setup) + int'(bad_stall);
            if (rise) begin
                cap[rise_cnt]      <= bit_m;
                rise_cyc[rise_cnt] <= cyc;
                rise_cnt           <= rise_cnt + 1;
            end
        end
    end

    // ---------------- Stimulus ---------------------------------------------
    logic [7:0] stream[0:31];
    int         hs_cnt = 0, first_stall = 0, drv_tmo = 0;
    bit         stop_drv = 1'b0;

    task automatic drive_bytes(input int n, input bit stalls);
        int guard;
        int s;
        hs_cnt = 0;
        for (int k = 0; k < n && !stop_drv; k++) begin
            if (stalls) begin
                byte_valid = 1'b0;
                s = int'($urandom_range(0, 5));
                if (k == 0) first_stall = s;
                repeat (s) @(negedge clk);
            end
            byte_data  = stream[k];
            byte_valid = 1'b1;
            guard = 0;
            while (!rdy_m && !stop_drv && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) drv_tmo++;
            if (rdy_m && !stop_drv) begin
                @(posedge clk);
                hs_cnt++;
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done_m && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; pulses start on the selected DUT and runs a full load.
    task automatic run_load(input int n, input bit stalls, output int cycles, output logic pe_after);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        fork
            drive_bytes(n, stalls);
            begin
                @(posedge clk);
                @(negedge clk);
                start1   = 1'b0;
                start2   = 1'b0;
                pe_after = pe_m;
                wait_done(cycles);
            end
        join
    endtask

    task automatic check_bits(input string tag, input int base, input int len);
        logic [255:0] got;
        logic [255:0] exp;
        logic [7:0]   b;
        got = '0;
        exp = '0;
        for (int i = 0; i < len; i++) begin
            b      = stream[i / 8];
            exp[i] = b[i % 8];
            got[i] = cap[base + i];
        end
        check(tag, got, exp);
    endtask

    int   base, d0, v0, cycles, guard;
    logic pe_after;

    initial begin
        // -------- reset state
        repeat (2) @(negedge clk);
        check("rst_ready", rdy1, 0);
        check("rst_cfg_bit", bit1, 0);
        check("rst_cfg_clk", cclk1, 0);
        check("rst_pal_en", pe1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_bitcnt", bc1, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // -------- full load, pattern k*0x1D, no stalls
        for (int k = 0; k < 32; k++) stream[k] = 8'(k * 8'h1D);
        base = rise_cnt; d0 = done_cnt; v0 = viol;
        run_load(25, 1'b0, cycles, pe_after);
        check("load1_done_seen", done_m, 1);
        check("load1_latency", cycles, 200 * 4 + 25);
        repeat (5) @(negedge clk);
        #1;
        check("load1_rises", rise_cnt - base, 200);
        check_bits("load1_bits", base, 200);
        check("load1_bitcnt", bc_m, 200);
        check("load1_pal_en", pe_m, 1);
        check("load1_busy", busy_m, 0);
        check("load1_ready", rdy_m, 0);
        check("load1_done_pulses", done_cnt - d0, 1);
        check("load1_bytes", hs_cnt, 25);

        // -------- restart from LOADED with the inverted pattern
        for (int k = 0; k < 32; k++) stream[k] = ~stream[k];
        @(negedge clk);
        base = rise_cnt; d0 = done_cnt;
        run_load(25, 1'b0, cycles, pe_after);
        check("restart_pe_fall", pe_after, 0);
        check("restart_latency", cycles, 825);
        @(negedge clk);
        #1;
        check("restart_rises", rise_cnt - base, 200);
        check_bits("restart_bits", base, 200);
        check("restart_pal_en", pe_m, 1);
        check("restart_done_pulses", done_cnt - d0, 1);

        // -------- backpressure: original stream with random idle gaps
        for (int k = 0; k < 32; k++) stream[k] = 8'(k * 8'h1D);
        @(negedge clk);
        base = rise_cnt;
        run_load(25, 1'b1, cycles, pe_after);
        check("bp_latency", cycles, 825 + ((first_stall > 1) ? first_stall - 1 : 0));
        @(negedge clk);
        #1;
        check("bp_rises", rise_cnt - base, 200);
        check_bits("bp_bits", base, 200);
        check("bp_bytes", hs_cnt, 25);
        check("bp_bitcnt", bc_m, 200);

        // -------- start and abort together in LOADED: abort wins
        @(negedge clk);
        start1 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        base = rise_cnt;
        check("sa_pal_en", pe_m, 0);
        check("sa_busy", busy_m, 0);
        repeat (10) @(negedge clk);
        #1;
        check("sa_no_edges", rise_cnt - base, 0);

        // -------- abort after 37 configuration clock edges
        @(negedge clk);
        base = rise_cnt;
        start1 = 1'b1;
        fork
            drive_bytes(25, 1'b0);
            begin
                @(negedge clk);
                start1 = 1'b0;
                guard = 0;
                while ((rise_cnt - base) < 37 && guard < 2000) begin @(negedge clk); guard++; end
                while (cclk_m && guard < 2000) begin @(negedge clk); guard++; end
                check("abort_reach_timeout", guard >= 2000, 0);
                abort = 1'b1;
                @(negedge clk);
                abort    = 1'b0;
                stop_drv = 1'b1;
                check("abort_busy", busy_m, 0);
                check("abort_pal_en", pe_m, 0);
                check("abort_bitcnt", bc_m, 37);
                check("abort_cfg_clk", cclk_m, 0);
                check("abort_cfg_bit", bit_m, 0);
                check("abort_ready", rdy_m, 0);
            end
        join
        stop_drv = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_edges", rise_cnt - base, 37);

        // -------- asynchronous reset in the middle of a HIGH phase
        @(negedge clk);
        base = rise_cnt;
        start1 = 1'b1;
        fork
            drive_bytes(25, 1'b0);
            begin
                @(negedge clk);
                start1 = 1'b0;
                guard = 0;
                while (!((rise_cnt - base) >= 5 && cclk_m) && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                end
                check("rst_reach_timeout", guard >= 2000, 0);
                #2 rst_n = 1'b0;
                #1;
                check("arst_cfg_clk", cclk1, 0);
                check("arst_cfg_bit", bit1, 0);
                check("arst_pal_en", pe1, 0);
                check("arst_busy", busy1, 0);
                check("arst_ready", rdy1, 0);
                stop_drv = 1'b1;
            end
        join
        stop_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        base = rise_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("post_rst_no_edges", rise_cnt - base, 0);
        check("post_rst_busy", busy1, 0);

        // -------- 190-bit stream, CLK_DIV=1, random bytes
        @(negedge clk);
        sel = 1'b1;
        for (int k = 0; k < 32; k++) stream[k] = 8'($urandom);
        repeat (2) @(negedge clk);
        base = rise_cnt; d0 = done_cnt;
        run_load(24, 1'b0, cycles, pe_after);
        check("fast_done_seen", done_m, 1);
        check("fast_latency", cycles, 190 * 2 + 24);
        repeat (3) @(negedge clk);
        #1;
        check("fast_rises", rise_cnt - base, 190);
        check_bits("fast_bits", base, 190);
        check("fast_bitcnt", bc_m, 190);
        check("fast_bytes", hs_cnt, 24);
        check("fast_pal_en", pe_m, 1);
        check("fast_period", rise_cyc[base + 1] - rise_cyc[base], 2);
        check("fast_done_pulses", done_cnt - d0, 1);

        check("protocol_violations", viol, 0);
        check("driver_timeouts", drv_tmo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
